lsu_ctrl: RTL and testbench

Load/store sequencer for the MEM stage of the core. It takes the load/store decode for the instruction in MEM and runs a request/grant/response transaction on the data-memory port. It stalls the pipeline until that transaction completes, then returns the aligned, sign- or zero-extended load data to writeback. It also detects misaligned accesses, illegal access sizes and bus timeouts.

---
 rtl/lsu_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: runs one request/grant/response bus transaction
// per load or store, stalls the pipeline until it completes and formats load data.
module lsu_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  // One spare bit so the saturated counter can never alias back onto TIMEOUT-1.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) + 1 : 1;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_SIZE     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e          state_q, state_d;
  logic            store_q, store_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            start;
  logic            stall;
  logic            illegal;
  logic            misaligned;
  logic            to_hit;
  logic [CW-1:0]   cnt_inc;
  logic [3:0]      be_new;
  logic [31:0]     wdata_new;
  logic [31:0]     shifted;
  logic [31:0]     load_fmt;

  assign start      = valid_i & (is_load_i | is_store_i);
  assign illegal    = (funct3_i == 3'b011) | (funct3_i[2:1] == 2'b11) | (is_store_i & funct3_i[2]);
  assign misaligned = ((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                      ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign to_hit     = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_new    = 4'b0001 << addr_i[1:0];
        wdata_new = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_new = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = mem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    load_fmt = shifted;
    case (f3_q)
      3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_fmt = {24'b0, shifted[7:0]};
      3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_fmt = {16'b0, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    f3_d    = f3_q;
    off_d   = off_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          stall   = 1'b1;
          store_d = is_store_i;
          f3_d    = funct3_i;
          off_d   = addr_i[1:0];
          be_d    = be_new;
          addr_d  = {addr_i[31:2], 2'b00};
          wdata_d = wdata_new;
          rdata_d = '0;
          cnt_d   = '0;
          if (illegal) begin
            err_d   = ERR_SIZE;
            state_d = S_DONE;
          end else if (misaligned) begin
            err_d   = ERR_MISALIGN;
            state_d = S_DONE;
          end else begin
            err_d   = ERR_NONE;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall = 1'b1;
        cnt_d = cnt_inc;
        if (mem_gnt_i) begin
          state_d = store_q ? S_DONE : S_WAIT;
        end else if (to_hit) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_inc;
        if (mem_rvalid_i) begin
          rdata_d = load_fmt;
          state_d = S_DONE;
        end else if (to_hit) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      store_q <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      be_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset also masks the combinational IDLE stall so the pipeline is released at once.
  assign stall_o     = stall & ~rst_i;
  assign done_o      = (state_q == S_DONE);
  assign err_o       = done_o & (err_q != ERR_NONE);
  assign err_code_o  = done_o ? err_q : ERR_NONE;
  assign rdata_o     = (done_o && err_q == ERR_NONE) ? rdata_q : 32'h0;
  assign mem_req_o   = (state_q == S_REQ);
  assign mem_we_o    = mem_req_o & store_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: two instances (TIMEOUT 16 and 4) behind an
// output mux, a bus responder inside the access driver, and a result scoreboard.
module tb_lsu_ctrl;

  localparam int TO_A = 16;
  localparam int TO_B = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        sel;
  logic        valid_i, is_load_i, is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i, mem_rdata_i;
  logic        mem_gnt_i, mem_rvalid_i;

  logic        a_stall, a_done, a_err, a_req, a_we;
  logic [1:0]  a_code;
  logic [3:0]  a_be;
  logic [31:0] a_rdata, a_addr, a_wdata;
  logic        b_stall, b_done, b_err, b_req, b_we;
  logic [1:0]  b_code;
  logic [3:0]  b_be;
  logic [31:0] b_rdata, b_addr, b_wdata;

  logic        o_stall, o_done, o_err, o_req, o_we;
  logic [1:0]  o_code;
  logic [3:0]  o_be;
  logic [31:0] o_rdata, o_addr, o_wdata;

  logic [34:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT(TO_A)) u_dut_a (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i & ~sel), .is_load_i(is_load_i),
    .is_store_i(is_store_i), .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(a_stall), .done_o(a_done), .rdata_o(a_rdata), .err_o(a_err),
    .err_code_o(a_code), .mem_req_o(a_req), .mem_we_o(a_we), .mem_be_o(a_be),
    .mem_addr_o(a_addr), .mem_wdata_o(a_wdata), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  lsu_ctrl #(.TIMEOUT(TO_B)) u_dut_b (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i & sel), .is_load_i(is_load_i),
    .is_store_i(is_store_i), .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(b_stall), .done_o(b_done), .rdata_o(b_rdata), .err_o(b_err),
    .err_code_o(b_code), .mem_req_o(b_req), .mem_we_o(b_we), .mem_be_o(b_be),
    .mem_addr_o(b_addr), .mem_wdata_o(b_wdata), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  assign o_stall = sel ? b_stall : a_stall;
  assign o_done  = sel ? b_done  : a_done;
  assign o_err   = sel ? b_err   : a_err;
  assign o_req   = sel ? b_req   : a_req;
  assign o_we    = sel ? b_we    : a_we;
  assign o_code  = sel ? b_code  : a_code;
  assign o_be    = sel ? b_be    : a_be;
  assign o_rdata = sel ? b_rdata : a_rdata;
  assign o_addr  = sel ? b_addr  : a_addr;
  assign o_wdata = sel ? b_wdata : a_wdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return s;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Cycle walk from REQ entry: g/r index the REQ/WAIT cycle carrying gnt/rvalid (-1 = never).
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] rd, input int g, input int r, input int to,
                       output int stall, output int nreq, output logic [34:0] res);
    logic [1:0]  code;
    logic [31:0] d;
    logic        in_w;
    int          k;
    code = 2'b00; d = '0; in_w = 1'b0; k = 0; stall = 1; nreq = 0;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (st && f3[2])) code = 2'b10;
    else if ((f3[1:0] == 2'b01 && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00)) code = 2'b01;
    if (code == 2'b00) begin
      for (int c = 0; c < 200; c++) begin
        stall++;
        if (!in_w) begin
          nreq++;
          if (c == g) begin
            if (st) break;
            in_w = 1'b1;
            continue;
          end
        end else begin
          if (k == r) begin
            d = fmt(f3, a[1:0], rd);
            break;
          end
          k++;
        end
        if (to != 0 && c == to - 1) begin
          code = 2'b11;
          break;
        end
      end
    end
    res = {code != 2'b00, code, d};
  endtask

  task automatic access(input string tag, input logic s, input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input int g, input int r, input logic [31:0] rd);
    int          es, er, nst, rc, wc, bad;
    logic [34:0] res, e;
    logic        in_w, got;
    model(st, f3, a, rd, g, r, s ? TO_B : TO_A, es, er, res);
    exp_q.push_back(res);
    @(negedge clk);
    sel = s; valid_i = 1'b1; is_load_i = ld; is_store_i = st;
    funct3_i = f3; addr_i = a; wdata_i = wd; mem_rdata_i = rd;
    nst = 0; rc = 0; wc = 0; bad = 0; in_w = 1'b0; got = 1'b0;
    for (int cyc = 0; cyc < 64 && !got; cyc++) begin
      if (cyc > 0) @(negedge clk);
      mem_gnt_i    = o_req && (rc == g);
      mem_rvalid_i = o_req || (in_w && wc == r);
      #1;
      if (o_stall) nst++;
      if (o_req) begin
        if (rc == 0) begin
          chk({tag, "_be"}, o_be, exp_be(f3, a[1:0]));
          chk({tag, "_addr"}, o_addr, {a[31:2], 2'b00});
          chk({tag, "_we"}, o_we, st);
          chk({tag, "_wdata"}, o_wdata, exp_wd(f3, wd));
        end else if (o_be !== exp_be(f3, a[1:0]) || o_addr !== {a[31:2], 2'b00} ||
                     o_we !== st || o_wdata !== exp_wd(f3, wd)) begin
          bad++;
        end
        rc++;
      end
      if (in_w) wc++;
      if (mem_gnt_i && ld) in_w = 1'b1;
      if (o_done) begin
        got = 1'b1;
        chk({tag, "_stall_in_done"}, o_stall, 1'b0);
        chk({tag, "_sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk({tag, "_result"}, {o_err, o_code, o_rdata}, e);
        end
      end
    end
    chk({tag, "_done_seen"}, got, 1'b1);
    chk({tag, "_stall_cycles"}, nst, es);
    chk({tag, "_req_cycles"}, rc, er);
    chk({tag, "_req_stable"}, bad, 0);
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  // Starts an LW, then pulses reset while the access sits in REQ or WAIT.
  task automatic rst_mid(input string tag, input logic in_wait);
    int nd;
    @(negedge clk);
    sel = 1'b0; valid_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0;
    funct3_i = 3'b010; addr_i = 32'h0000_4000; wdata_i = '0; mem_rdata_i = 32'h55AA_0FF0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    @(negedge clk);
    #1 chk({tag, "_in_req"}, o_req, 1'b1);
    mem_gnt_i = in_wait;
    if (in_wait) begin
      @(negedge clk);
      mem_gnt_i = 1'b0;
      #1 chk({tag, "_in_wait"}, {o_stall, o_req}, 2'b10);
    end
    #2 rst_i = 1'b1;
    #1;
    chk({tag, "_req_dropped"}, o_req, 1'b0);
    chk({tag, "_stall_dropped"}, o_stall, 1'b0);
    chk({tag, "_no_done_now"}, o_done, 1'b0);
    @(negedge clk);
    valid_i = 1'b0;
    rst_i = 1'b0;
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      #1 if (o_done) nd++;
    end
    chk({tag, "_no_done_after"}, nd, 0);
  endtask

  initial begin
    rst_i = 1'b1; sel = 1'b0; valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
    funct3_i = 3'b000; addr_i = '0; wdata_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", o_stall, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_err", {o_err, o_code}, 3'b000);
    chk("rst_req", {a_req, b_req, o_we}, 3'b000);
    chk("rst_be", o_be, 4'b0000);
    chk("rst_addr", o_addr, 32'h0);
    chk("rst_wdata", o_wdata, 32'h0);
    chk("rst_rdata", o_rdata, 32'h0);
    @(negedge clk);
    rst_i = 1'b0;

    access("sw",      1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 0, 0, 32'h0);
    access("sb",      1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0);
    access("sh",      1'b0, 1'b0, 1'b1, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 1, 0, 32'h0);
    access("lb",      1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0, 0, 0, 32'h1234_80FF);
    access("lbu",     1'b0, 1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'h0, 0, 0, 32'h1234_80FF);
    access("lhu",     1'b0, 1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 0, 0, 32'h1234_80FF);
    access("lh",      1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_2000, 32'h0, 0, 0, 32'h0000_8001);
    access("lw_dly",  1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_2008, 32'h0, 2, 1, 32'hCAFE_F00D);
    access("lw_mis",  1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 0, 0, 32'hFFFF_FFFF);
    access("sw_bu",   1'b0, 1'b0, 1'b1, 3'b100, 32'h0000_3000, 32'h1111_2222, 0, 0, 32'h0);
    access("lh_mis",  1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_3001, 32'h0, 0, 0, 32'h1234_5678);
    access("ld_f011", 1'b0, 1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'h0, 0, 0, 32'h1234_5678);
    access("lw_to",   1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, -1, 0, 32'h0000_0001);
    access("lw_edge", 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_5004, 32'h0, 3, 0, 32'h8765_4321);
    access("lw_wto",  1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_5008, 32'h0, 0, -1, 32'h1357_9BDF);
    access("sw_edge", 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_500C, 32'h1357_9BDF, 3, 0, 32'h0);

    for (int i = 0; i < 24; i++) begin
      logic        ld, s;
      logic [2:0]  f3;
      logic [31:0] a, wd, rd;
      int          g, r;
      ld = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom();
      wd = $urandom();
      rd = $urandom();
      if ($urandom_range(0, 1) == 1) begin
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
        else if (f3[1:0] == 2'b01) a[0] = 1'b0;
      end
      g = $urandom_range(0, 5);
      if (g == 5) g = -1;
      r = $urandom_range(0, 3);
      access($sformatf("rnd%0d", i), s, ld, ~ld, f3, a, wd, g, r, rd);
    end

    rst_mid("rst_req", 1'b0);
    rst_mid("rst_wait", 1'b1);
    access("lw_after", 1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 0, 0, 32'h0BAD_F00D);

    @(negedge clk);
    valid_i = 1'b0;
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
